// File: rtl/ring_rsp_tile_if.sv
// Ring link types and the bundled request/response ring ports of the responder tile.
// Every ring channel is fire-and-forget: valid only, nothing on the ring is ever stalled.
package ring_rsp_tile_pkg;
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RD     = 3'd1,
    OP_WR     = 3'd2,
    OP_RD_RSP = 3'd3,
    OP_WR_RSP = 3'd4
  } t_opcode;

  typedef struct packed {
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_msg;
endpackage

interface ring_rsp_tile_if;
  import ring_rsp_tile_pkg::*;

  logic        RingReqInValidQ500H;
  logic [9:0]  RingReqInRequestorQ500H;
  t_opcode     RingReqInOpcodeQ500H;
  logic [31:0] RingReqInAddressQ500H;
  logic [31:0] RingReqInDataQ500H;

  logic        RingRspInValidQ500H;
  logic [9:0]  RingRspInRequestorQ500H;
  t_opcode     RingRspInOpcodeQ500H;
  logic [31:0] RingRspInAddressQ500H;
  logic [31:0] RingRspInDataQ500H;

  logic        RingReqOutValidQ502H;
  logic [9:0]  RingReqOutRequestorQ502H;
  t_opcode     RingReqOutOpcodeQ502H;
  logic [31:0] RingReqOutAddressQ502H;
  logic [31:0] RingReqOutDataQ502H;

  logic        RingRspOutValidQ502H;
  logic [9:0]  RingRspOutRequestorQ502H;
  t_opcode     RingRspOutOpcodeQ502H;
  logic [31:0] RingRspOutAddressQ502H;
  logic [31:0] RingRspOutDataQ502H;

  // Tile side
  modport slave (
    input  RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
           RingReqInAddressQ500H, RingReqInDataQ500H,
           RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
           RingRspInAddressQ500H, RingRspInDataQ500H,
    output RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
           RingReqOutAddressQ502H, RingReqOutDataQ502H,
           RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
           RingRspOutAddressQ502H, RingRspOutDataQ502H
  );

  // Ring side
  modport master (
    output RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
           RingReqInAddressQ500H, RingReqInDataQ500H,
           RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
           RingRspInAddressQ500H, RingRspInDataQ500H,
    input  RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
           RingReqOutAddressQ502H, RingReqOutDataQ502H,
           RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
           RingRspOutAddressQ502H, RingRspOutDataQ502H
  );
endinterface

// File: rtl/ring_rsp_tile.sv
// Ring responder: claims RD/WR for TileID, serves them from local memory, 2-cycle Q500H->Q502H pipe.
// Never stalls the ring; when the response buffer cannot take another entry the request bounces.
module ring_rsp_tile
  import ring_rsp_tile_pkg::*;
#(
  parameter int MEM_WORDS      = 1024,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                              QClk,
  input  logic                              RstQnnnL,
  input  logic [7:0]                        TileID,
  ring_rsp_tile_if.slave                    ring,
  output logic [$clog2(RSP_FIFO_DEPTH):0]   RspFifoCount
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;

  t_ring_msg req_in_msg, rsp_in_msg;
  assign req_in_msg = '{requestor: ring.RingReqInRequestorQ500H, opcode: ring.RingReqInOpcodeQ500H,
                        address: ring.RingReqInAddressQ500H, data: ring.RingReqInDataQ500H};
  assign rsp_in_msg = '{requestor: ring.RingRspInRequestorQ500H, opcode: ring.RingRspInOpcodeQ500H,
                        address: ring.RingRspInAddressQ500H, data: ring.RingRspInDataQ500H};

  // Q501H stage
  logic      req_fwd_vld_q, req_fwd_vld_d;
  t_ring_msg req_fwd_q, req_fwd_d;
  logic      rsp_fwd_vld_q, rsp_fwd_vld_d;
  t_ring_msg rsp_fwd_q, rsp_fwd_d;
  logic      gen_vld_q, gen_vld_d;
  t_ring_msg gen_q, gen_d;
  // Q502H stage
  logic      req_out_vld_q, req_out_vld_d;
  t_ring_msg req_out_q, req_out_d;
  logic      rsp_out_vld_q, rsp_out_vld_d;
  t_ring_msg rsp_out_q, rsp_out_d;
  // response buffer
  t_ring_msg         fifo_q [RSP_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  logic [31:0]       mem_q [MEM_WORDS];
  logic [IW-1:0]     gen_idx;
  t_ring_msg         gen_rsp;
  logic              claim;

  // A claimed request reserves a buffer slot for its response before it reaches Q501H.
  always_comb begin
    claim = ring.RingReqInValidQ500H
         && (ring.RingReqInOpcodeQ500H == OP_RD || ring.RingReqInOpcodeQ500H == OP_WR)
         && (ring.RingReqInAddressQ500H[31:24] == TileID)
         && ((int'(count_q) + int'(gen_vld_q)) < RSP_FIFO_DEPTH);
  end

  always_comb begin
    req_fwd_vld_d = ring.RingReqInValidQ500H && !claim;
    req_fwd_d     = req_fwd_vld_d ? req_in_msg : '0;
    rsp_fwd_vld_d = ring.RingRspInValidQ500H;
    rsp_fwd_d     = rsp_fwd_vld_d ? rsp_in_msg : '0;
    gen_vld_d     = claim;
    gen_d         = claim ? req_in_msg : '0;
  end

  // Memory is read asynchronously here, so a write retired last cycle is already visible.
  always_comb begin
    gen_idx           = gen_q.address[IW+1:2];
    gen_rsp           = gen_q;
    gen_rsp.opcode    = (gen_q.opcode == OP_WR) ? OP_WR_RSP : OP_RD_RSP;
    gen_rsp.data      = (gen_q.opcode == OP_WR) ? gen_q.data : mem_q[gen_idx];
  end

  always_comb begin
    rsp_out_vld_d = 1'b0;
    rsp_out_d     = '0;
    push          = 1'b0;
    pop           = 1'b0;
    if (rsp_fwd_vld_q) begin
      rsp_out_vld_d = 1'b1;
      rsp_out_d     = rsp_fwd_q;
      push          = gen_vld_q;
    end else if (count_q != '0) begin
      rsp_out_vld_d = 1'b1;
      rsp_out_d     = fifo_q[rd_ptr_q];
      pop           = 1'b1;
      push          = gen_vld_q;
    end else if (gen_vld_q) begin
      rsp_out_vld_d = 1'b1;
      rsp_out_d     = gen_rsp;
    end
    req_out_vld_d = req_fwd_vld_q;
    req_out_d     = req_fwd_q;
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      req_fwd_vld_q <= 1'b0;
      req_fwd_q     <= '0;
      rsp_fwd_vld_q <= 1'b0;
      rsp_fwd_q     <= '0;
      gen_vld_q     <= 1'b0;
      gen_q         <= '0;
      req_out_vld_q <= 1'b0;
      req_out_q     <= '0;
      rsp_out_vld_q <= 1'b0;
      rsp_out_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      req_fwd_vld_q <= req_fwd_vld_d;
      req_fwd_q     <= req_fwd_d;
      rsp_fwd_vld_q <= rsp_fwd_vld_d;
      rsp_fwd_q     <= rsp_fwd_d;
      gen_vld_q     <= gen_vld_d;
      gen_q         <= gen_d;
      req_out_vld_q <= req_out_vld_d;
      req_out_q     <= req_out_d;
      rsp_out_vld_q <= rsp_out_vld_d;
      rsp_out_q     <= rsp_out_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage arrays carry no reset; memory contents survive a tile reset.
  always_ff @(posedge QClk) begin
    if (RstQnnnL && push) fifo_q[wr_ptr_q] <= gen_rsp;
    if (RstQnnnL && gen_vld_q && gen_q.opcode == OP_WR) mem_q[gen_idx] <= gen_q.data;
  end

  overflow_chk: assert property (@(posedge QClk) disable iff (!RstQnnnL)
                                 !(push && !pop && count_q == CW'(RSP_FIFO_DEPTH)));

  assign ring.RingReqOutValidQ502H     = req_out_vld_q;
  assign ring.RingReqOutRequestorQ502H = req_out_q.requestor;
  assign ring.RingReqOutOpcodeQ502H    = req_out_q.opcode;
  assign ring.RingReqOutAddressQ502H   = req_out_q.address;
  assign ring.RingReqOutDataQ502H      = req_out_q.data;
  assign ring.RingRspOutValidQ502H     = rsp_out_vld_q;
  assign ring.RingRspOutRequestorQ502H = rsp_out_q.requestor;
  assign ring.RingRspOutOpcodeQ502H    = rsp_out_q.opcode;
  assign ring.RingRspOutAddressQ502H   = rsp_out_q.address;
  assign ring.RingRspOutDataQ502H      = rsp_out_q.data;
  assign RspFifoCount                  = count_q;
endmodule

// File: tb/tb_ring_rsp_tile.sv
// Directed bench for ring_rsp_tile: claim, pass-through, priority, buffering/bounce, RAW and reset flush.
module tb_ring_rsp_tile;
  import ring_rsp_tile_pkg::*;

  logic       QClk = 1'b0;
  logic       RstQnnnL;
  logic [7:0] TileID;
  logic [2:0] RspFifoCount;
  int         n_checks = 0;
  int         n_fail = 0;

  ring_rsp_tile_if rif ();

  ring_rsp_tile #(.MEM_WORDS(1024), .RSP_FIFO_DEPTH(4)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .TileID(TileID), .ring(rif), .RspFifoCount(RspFifoCount)
  );

  always #5 QClk = ~QClk;

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [9:0] r, input t_opcode op,
                           input logic [31:0] a, input logic [31:0] d);
    rif.RingReqInValidQ500H     = v;
    rif.RingReqInRequestorQ500H = r;
    rif.RingReqInOpcodeQ500H    = op;
    rif.RingReqInAddressQ500H   = a;
    rif.RingReqInDataQ500H      = d;
  endtask

  task automatic drive_rsp(input logic v, input logic [9:0] r, input t_opcode op,
                           input logic [31:0] a, input logic [31:0] d);
    rif.RingRspInValidQ500H     = v;
    rif.RingRspInRequestorQ500H = r;
    rif.RingRspInOpcodeQ500H    = op;
    rif.RingRspInAddressQ500H   = a;
    rif.RingRspInDataQ500H      = d;
  endtask

  task automatic idle();
    drive_req(1'b0, 10'h0, OP_NOP, 32'h0, 32'h0);
    drive_rsp(1'b0, 10'h0, OP_NOP, 32'h0, 32'h0);
  endtask

  task automatic mem_write(input int idx, input logic [31:0] d);
    drive_req(1'b1, 10'h3FF, OP_WR, 32'h0500_0000 + 32'(idx * 4), d);
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    RstQnnnL = 1'b0;
    idle();
    tick();
    tick();
    n_checks++; if (rif.RingReqOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL reset_req_vld got %b want 0", rif.RingReqOutValidQ502H); end
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_vld got %b want 0", rif.RingRspOutValidQ502H); end
    n_checks++; if (RspFifoCount !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", RspFifoCount); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rif.RingRspOutDataQ502H); end
    n_checks++; if (rif.RingReqOutAddressQ502H !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr got %h want 0", rif.RingReqOutAddressQ502H); end
    RstQnnnL = 1'b1;
    tick();
  endtask

  task automatic test_wr_rd();
    drive_req(1'b1, 10'h008, OP_WR, 32'h0500_0010, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_vld got %b want 1", rif.RingRspOutValidQ502H); end
    n_checks++; if (rif.RingRspOutOpcodeQ502H !== OP_WR_RSP) begin n_fail++; $display("FAIL wr_rsp_op got %0d want %0d", rif.RingRspOutOpcodeQ502H, OP_WR_RSP); end
    n_checks++; if (rif.RingRspOutRequestorQ502H !== 10'h008) begin n_fail++; $display("FAIL wr_rsp_req got %h want 008", rif.RingRspOutRequestorQ502H); end
    n_checks++; if (rif.RingRspOutAddressQ502H !== 32'h0500_0010) begin n_fail++; $display("FAIL wr_rsp_addr got %h want 05000010", rif.RingRspOutAddressQ502H); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rsp_data got %h want deadbeef", rif.RingRspOutDataQ502H); end
    n_checks++; if (rif.RingReqOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL wr_claim_req_vld got %b want 0", rif.RingReqOutValidQ502H); end
    drive_req(1'b1, 10'h008, OP_RD, 32'h0500_0010, 32'h0);
    tick();
    idle();
    tick();
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_vld got %b want 1", rif.RingRspOutValidQ502H); end
    n_checks++; if (rif.RingRspOutOpcodeQ502H !== OP_RD_RSP) begin n_fail++; $display("FAIL rd_rsp_op got %0d want %0d", rif.RingRspOutOpcodeQ502H, OP_RD_RSP); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rsp_data got %h want deadbeef", rif.RingRspOutDataQ502H); end
    n_checks++; if (rif.RingReqOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL rd_claim_req_vld got %b want 0", rif.RingReqOutValidQ502H); end
    tick();
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drain got %b want 0", rif.RingRspOutValidQ502H); end
  endtask

  task automatic test_foreign();
    drive_req(1'b1, 10'h021, OP_RD, 32'h0300_0040, 32'h1111_2222);
    tick();
    idle();
    tick();
    n_checks++; if (rif.RingReqOutValidQ502H !== 1'b1) begin n_fail++; $display("FAIL fwd_req_vld got %b want 1", rif.RingReqOutValidQ502H); end
    n_checks++; if (rif.RingReqOutRequestorQ502H !== 10'h021) begin n_fail++; $display("FAIL fwd_req_req got %h want 021", rif.RingReqOutRequestorQ502H); end
    n_checks++; if (rif.RingReqOutOpcodeQ502H !== OP_RD) begin n_fail++; $display("FAIL fwd_req_op got %0d want %0d", rif.RingReqOutOpcodeQ502H, OP_RD); end
    n_checks++; if (rif.RingReqOutAddressQ502H !== 32'h0300_0040) begin n_fail++; $display("FAIL fwd_req_addr got %h want 03000040", rif.RingReqOutAddressQ502H); end
    n_checks++; if (rif.RingReqOutDataQ502H !== 32'h1111_2222) begin n_fail++; $display("FAIL fwd_req_data got %h want 11112222", rif.RingReqOutDataQ502H); end
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL fwd_req_no_rsp got %b want 0", rif.RingRspOutValidQ502H); end
    tick();
  endtask

  task automatic test_rsp_priority();
    mem_write(0, 32'h0BAD_F00D);
    drive_req(1'b1, 10'h010, OP_RD, 32'h0500_0000, 32'h0);
    drive_rsp(1'b1, 10'h00C, OP_RD_RSP, 32'h0900_0004, 32'h1234_5678);
    tick();
    idle();
    n_checks++; if (RspFifoCount !== 3'd0) begin n_fail++; $display("FAIL prio_count_n1 got %0d want 0", RspFifoCount); end
    tick();
    n_checks++; if (rif.RingRspOutRequestorQ502H !== 10'h00C || rif.RingRspOutValidQ502H !== 1'b1) begin n_fail++; $display("FAIL prio_fwd_first got vld %b req %h want 1 00c", rif.RingRspOutValidQ502H, rif.RingRspOutRequestorQ502H); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'h1234_5678) begin n_fail++; $display("FAIL prio_fwd_data got %h want 12345678", rif.RingRspOutDataQ502H); end
    n_checks++; if (RspFifoCount !== 3'd1) begin n_fail++; $display("FAIL prio_count_peak got %0d want 1", RspFifoCount); end
    tick();
    n_checks++; if (rif.RingRspOutRequestorQ502H !== 10'h010 || rif.RingRspOutOpcodeQ502H !== OP_RD_RSP) begin n_fail++; $display("FAIL prio_gen_second got req %h op %0d want 010 %0d", rif.RingRspOutRequestorQ502H, rif.RingRspOutOpcodeQ502H, OP_RD_RSP); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL prio_gen_data got %h want 0badf00d", rif.RingRspOutDataQ502H); end
    n_checks++; if (RspFifoCount !== 3'd0) begin n_fail++; $display("FAIL prio_count_end got %0d want 0", RspFifoCount); end
    tick();
  endtask

  task automatic test_fill_bounce();
    int max_cnt = 0;
    for (int i = 0; i < 4; i++) mem_write(i, 32'h1000_0000 + 32'(i));
    for (int c = 0; c < 18; c++) begin
      if (int'(RspFifoCount) > max_cnt) max_cnt = int'(RspFifoCount);
      if (c == 6 || c == 7) begin
        n_checks++; if (rif.RingReqOutValidQ502H !== 1'b1 || rif.RingReqOutRequestorQ502H !== 10'(64 + c - 2)) begin n_fail++; $display("FAIL bounce_req c%0d got vld %b req %h want 1 %h", c, rif.RingReqOutValidQ502H, rif.RingReqOutRequestorQ502H, 10'(64 + c - 2)); end
        n_checks++; if (rif.RingReqOutAddressQ502H !== 32'h0500_0000 + 32'((c - 2) * 4) || rif.RingReqOutOpcodeQ502H !== OP_RD || rif.RingReqOutDataQ502H !== 32'h7700_0000 + 32'(c - 2)) begin n_fail++; $display("FAIL bounce_fields c%0d got %h %0d %h", c, rif.RingReqOutAddressQ502H, rif.RingReqOutOpcodeQ502H, rif.RingReqOutDataQ502H); end
      end else begin
        n_checks++; if (rif.RingReqOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL bounce_req_idle c%0d got %b want 0", c, rif.RingReqOutValidQ502H); end
      end
      if (c >= 2 && c <= 11) begin
        n_checks++; if (rif.RingRspOutValidQ502H !== 1'b1 || rif.RingRspOutRequestorQ502H !== 10'(256 + c - 2) || rif.RingRspOutDataQ502H !== 32'(c - 2)) begin n_fail++; $display("FAIL fill_fwd c%0d got vld %b req %h data %h", c, rif.RingRspOutValidQ502H, rif.RingRspOutRequestorQ502H, rif.RingRspOutDataQ502H); end
      end else if (c >= 12 && c <= 15) begin
        n_checks++; if (rif.RingRspOutValidQ502H !== 1'b1 || rif.RingRspOutRequestorQ502H !== 10'(64 + c - 12) || rif.RingRspOutOpcodeQ502H !== OP_RD_RSP) begin n_fail++; $display("FAIL fill_gen c%0d got vld %b req %h op %0d", c, rif.RingRspOutValidQ502H, rif.RingRspOutRequestorQ502H, rif.RingRspOutOpcodeQ502H); end
        n_checks++; if (rif.RingRspOutDataQ502H !== 32'h1000_0000 + 32'(c - 12)) begin n_fail++; $display("FAIL fill_gen_data c%0d got %h want %h", c, rif.RingRspOutDataQ502H, 32'h1000_0000 + 32'(c - 12)); end
      end else begin
        n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL fill_rsp_idle c%0d got %b want 0", c, rif.RingRspOutValidQ502H); end
      end
      if (c <= 5) drive_req(1'b1, 10'(64 + c), OP_RD, 32'h0500_0000 + 32'(c * 4), 32'h7700_0000 + 32'(c));
      else drive_req(1'b0, 10'h0, OP_NOP, 32'h0, 32'h0);
      if (c <= 9) drive_rsp(1'b1, 10'(256 + c), OP_RD_RSP, 32'h0800_0000, 32'(c));
      else drive_rsp(1'b0, 10'h0, OP_NOP, 32'h0, 32'h0);
      tick();
    end
    n_checks++; if (max_cnt != 4) begin n_fail++; $display("FAIL fill_count_peak got %0d want 4", max_cnt); end
    n_checks++; if (RspFifoCount !== 3'd0) begin n_fail++; $display("FAIL fill_count_end got %0d want 0", RspFifoCount); end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 10'h033, OP_WR, 32'h0500_000C, 32'hA5A5_A5A5);
    tick();
    drive_req(1'b1, 10'h034, OP_RD, 32'h0500_000C, 32'h0);
    tick();
    idle();
    n_checks++; if (rif.RingRspOutOpcodeQ502H !== OP_WR_RSP || rif.RingRspOutRequestorQ502H !== 10'h033) begin n_fail++; $display("FAIL raw_wr_rsp got op %0d req %h", rif.RingRspOutOpcodeQ502H, rif.RingRspOutRequestorQ502H); end
    tick();
    n_checks++; if (rif.RingRspOutOpcodeQ502H !== OP_RD_RSP || rif.RingRspOutRequestorQ502H !== 10'h034) begin n_fail++; $display("FAIL raw_rd_rsp got op %0d req %h", rif.RingRspOutOpcodeQ502H, rif.RingRspOutRequestorQ502H); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL raw_rd_data got %h want a5a5a5a5", rif.RingRspOutDataQ502H); end
    tick();
  endtask

  task automatic test_reset_flush();
    for (int c = 0; c < 4; c++) begin
      if (c <= 2) drive_req(1'b1, 10'(80 + c), OP_RD, 32'h0500_0000 + 32'(c * 4), 32'h0);
      else drive_req(1'b0, 10'h0, OP_NOP, 32'h0, 32'h0);
      drive_rsp(1'b1, 10'(384 + c), OP_RD_RSP, 32'h0800_0000, 32'(c));
      tick();
    end
    idle();
    n_checks++; if (RspFifoCount !== 3'd3) begin n_fail++; $display("FAIL flush_prefill got %0d want 3", RspFifoCount); end
    RstQnnnL = 1'b0;
    tick();
    RstQnnnL = 1'b1;
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0 || rif.RingReqOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL flush_valids got rsp %b req %b want 0 0", rif.RingRspOutValidQ502H, rif.RingReqOutValidQ502H); end
    n_checks++; if (RspFifoCount !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", RspFifoCount); end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++; if (rif.RingRspOutValidQ502H !== 1'b0) begin n_fail++; $display("FAIL flush_stale c%0d got %b want 0", c, rif.RingRspOutValidQ502H); end
    end
    drive_req(1'b1, 10'h055, OP_RD, 32'h0500_0008, 32'h0);
    tick();
    idle();
    tick();
    n_checks++; if (rif.RingRspOutValidQ502H !== 1'b1 || rif.RingRspOutRequestorQ502H !== 10'h055) begin n_fail++; $display("FAIL flush_rd_rsp got vld %b req %h want 1 055", rif.RingRspOutValidQ502H, rif.RingRspOutRequestorQ502H); end
    n_checks++; if (rif.RingRspOutDataQ502H !== 32'h1000_0002) begin n_fail++; $display("FAIL flush_mem_kept got %h want 10000002", rif.RingRspOutDataQ502H); end
    tick();
  endtask

  initial begin
    TileID = 8'h05;
    RstQnnnL = 1'b0;
    idle();
    test_reset();
    test_wr_rd();
    test_foreign();
    test_rsp_priority();
    test_fill_bounce();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
